// File: rtl/pc_control_pkg.sv
// Shared types and constants for the program-counter control block.
package pc_control_pkg;

   // Branch condition codes carried in the instruction word.
   typedef enum logic [2:0] {
      BNE = 3'b000,
      BE  = 3'b001,
      BGT = 3'b010,
      BLT = 3'b011,
      BGE = 3'b100,
      BLE = 3'b101,
      BO  = 3'b110,
      UCD = 3'b111
   } cond_t;

   // Sequential step: one instruction word is two bytes.
   localparam logic [15:0] PC_INC   = 16'd2;
   localparam logic [15:0] PC_RESET = 16'h0000;

endpackage : pc_control_pkg

// File: rtl/pc_control_cond_eval.sv
// Combinational branch-condition evaluator: decides whether condition c
// holds on flags f = {N, O, Z}. Bits not used by a condition are ignored.
import pc_control_pkg::*;

module cond_eval (
   input  cond_t       c,
   input  logic [2:0]  f,
   output logic        cond_true
);

   logic flag_n;
   logic flag_o;
   logic flag_z;

   assign flag_n = f[2];
   assign flag_o = f[1];
   assign flag_z = f[0];

   // Decode the condition code against the relevant flag bits.
   always_comb begin
      cond_true = 1'b0;
      case (c)
         BNE:     cond_true = ~flag_z;
         BE:      cond_true = flag_z;
         BGT:     cond_true = ~flag_z & ~flag_n;
         BLT:     cond_true = flag_n;
         BGE:     cond_true = flag_z | (~flag_z & ~flag_n);
         BLE:     cond_true = flag_n | flag_z;
         BO:      cond_true = flag_o;
         UCD:     cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule : cond_eval

// File: rtl/pc_control.sv
// Next-PC computation: sequential increment or PC-relative branch target,
// selected by the evaluated branch condition and registered once per clock.
import pc_control_pkg::*;

module pc_control (
   input  logic               clk,
   input  logic               rst,
   input  logic               branch,
   input  cond_t              c,
   input  logic signed [8:0]  imm,
   input  logic [2:0]         f,
   input  logic [15:0]        pc_in,
   output logic [15:0]        pc_out,
   output logic               taken
);

   logic        cond_true;
   logic [15:0] seq;
   logic [15:0] imm_ext;
   logic [15:0] tgt;
   logic        take;
   logic [15:0] pc_out_d;
   logic [15:0] pc_out_q;
   logic        taken_d;
   logic        taken_q;

   cond_eval u_cond_eval (
      .c         (c),
      .f         (f),
      .cond_true (cond_true)
   );

   // Address arithmetic and next-PC selection; all sums wrap modulo 2^16.
   always_comb begin
      seq      = pc_in + PC_INC;
      imm_ext  = {{7{imm[8]}}, imm};
      tgt      = seq + {imm_ext[14:0], 1'b0};
      take     = branch & cond_true;
      pc_out_d = take ? tgt : seq;
      taken_d  = take;
   end

   // Output registers; reset clears them immediately regardless of clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out_q <= PC_RESET;
         taken_q  <= 1'b0;
      end else begin
         pc_out_q <= pc_out_d;
         taken_q  <= taken_d;
      end
   end

   assign pc_out = pc_out_q;
   assign taken  = taken_q;

endmodule : pc_control

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed cases plus randomized
// stimulus compared against an arithmetic reference model.
import pc_control_pkg::*;

module tb_pc_control;

   logic               clk = 1'b0;
   logic               rst;
   logic               branch;
   cond_t              c;
   logic signed [8:0]  imm;
   logic [2:0]         f;
   logic [15:0]        pc_in;
   logic [15:0]        pc_out;
   logic               taken;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_control dut (
      .clk    (clk),
      .rst    (rst),
      .branch (branch),
      .c      (c),
      .imm    (imm),
      .f      (f),
      .pc_in  (pc_in),
      .pc_out (pc_out),
      .taken  (taken)
   );

   // Reference: condition truth table written from the flag rules.
   function automatic bit model_cond(input int code, input logic [2:0] flags);
      bit n;
      bit o;
      bit z;
      n = flags[2];
      o = flags[1];
      z = flags[0];
      case (code)
         0: return !z;
         1: return z;
         2: return !z && !n;
         3: return n;
         4: return z || (!z && !n);
         5: return n || z;
         6: return o;
         default: return 1'b1;
      endcase
   endfunction

   // Reference: next PC by integer arithmetic, reduced modulo 65536.
   function automatic logic [15:0] model_pc(input bit tk, input int pc, input int off);
      int v;
      v = pc + 2;
      if (tk) v = v + off * 2;
      v = ((v % 65536) + 65536) % 65536;
      return v[15:0];
   endfunction

   // Drive one set of inputs on the falling edge.
   task automatic drive(input bit br, input int code, input logic [2:0] flags,
                        input int off, input int pc);
      logic [8:0]  imm_bits;
      logic [15:0] pc_bits;
      @(negedge clk);
      imm_bits = off[8:0];
      pc_bits  = pc[15:0];
      branch = br;
      c      = cond_t'(code[2:0]);
      f      = flags;
      imm    = imm_bits;
      pc_in  = pc_bits;
   endtask

   // Apply inputs, let one rising edge pass and sample just after it.
   task automatic step(input bit br, input int code, input logic [2:0] flags,
                       input int off, input int pc);
      drive(br, code, flags, off, pc);
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs();
      branch = 1'($urandom);
      c      = cond_t'(3'($urandom));
      f      = 3'($urandom);
      imm    = 9'($urandom);
      pc_in  = 16'($urandom);
   endtask

   task automatic test_reset();
      randomize_inputs();
      rst = 1'b1;
      #1;
      checks++;
      if (pc_out !== 16'h0000 || taken !== 1'b0) begin
         failures++;
         $display("FAIL reset_immediate pc_out=%h taken=%b want pc_out=0000 taken=0", pc_out, taken);
      end else $display("reset_immediate pc_out=%h taken=%b", pc_out, taken);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         randomize_inputs();
         @(posedge clk);
         #1;
         checks++;
         if (pc_out !== 16'h0000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold%0d pc_out=%h taken=%b want pc_out=0000 taken=0", i, pc_out, taken);
         end else $display("reset_hold%0d pc_out=%h taken=%b", i, pc_out, taken);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      // sequential path
      step(1'b0, 7, 3'b000, 0, 16'h0100);
      checks++;
      if (pc_out !== 16'h0102 || taken !== 1'b0) begin
         failures++;
         $display("FAIL seq_path pc_out=%h taken=%b want pc_out=0102 taken=0", pc_out, taken);
      end else $display("seq_path pc_out=%h taken=%b", pc_out, taken);
      // forward taken
      step(1'b1, 1, 3'b001, 3, 16'h0100);
      checks++;
      if (pc_out !== 16'h0108 || taken !== 1'b1) begin
         failures++;
         $display("FAIL fwd_taken pc_out=%h taken=%b want pc_out=0108 taken=1", pc_out, taken);
      end else $display("fwd_taken pc_out=%h taken=%b", pc_out, taken);
      // not taken
      step(1'b1, 0, 3'b001, 3, 16'h0100);
      checks++;
      if (pc_out !== 16'h0102 || taken !== 1'b0) begin
         failures++;
         $display("FAIL not_taken pc_out=%h taken=%b want pc_out=0102 taken=0", pc_out, taken);
      end else $display("not_taken pc_out=%h taken=%b", pc_out, taken);
      // backward
      step(1'b1, 3, 3'b100, -4, 16'h0010);
      checks++;
      if (pc_out !== 16'h000A || taken !== 1'b1) begin
         failures++;
         $display("FAIL backward pc_out=%h taken=%b want pc_out=000a taken=1", pc_out, taken);
      end else $display("backward pc_out=%h taken=%b", pc_out, taken);
      // overflow branch wraps to 0
      step(1'b1, 6, 3'b010, 1, 16'hFFFC);
      checks++;
      if (pc_out !== 16'h0000 || taken !== 1'b1) begin
         failures++;
         $display("FAIL bo_wrap pc_out=%h taken=%b want pc_out=0000 taken=1", pc_out, taken);
      end else $display("bo_wrap pc_out=%h taken=%b", pc_out, taken);
      // sequential wrap
      step(1'b0, 7, 3'b111, 255, 16'hFFFE);
      checks++;
      if (pc_out !== 16'h0000 || taken !== 1'b0) begin
         failures++;
         $display("FAIL seq_wrap pc_out=%h taken=%b want pc_out=0000 taken=0", pc_out, taken);
      end else $display("seq_wrap pc_out=%h taken=%b", pc_out, taken);
      // most negative offset below address 0 wraps to the top
      step(1'b1, 7, 3'b000, -256, 16'h0000);
      checks++;
      if (pc_out !== 16'hFE02 || taken !== 1'b1) begin
         failures++;
         $display("FAIL neg_wrap pc_out=%h taken=%b want pc_out=fe02 taken=1", pc_out, taken);
      end else $display("neg_wrap pc_out=%h taken=%b", pc_out, taken);
      // most positive offset, and zero offset
      step(1'b1, 7, 3'b000, 255, 16'h1000);
      checks++;
      if (pc_out !== 16'h1200 || taken !== 1'b1) begin
         failures++;
         $display("FAIL max_fwd pc_out=%h taken=%b want pc_out=1200 taken=1", pc_out, taken);
      end else $display("max_fwd pc_out=%h taken=%b", pc_out, taken);
      step(1'b1, 7, 3'b000, 0, 16'h2000);
      checks++;
      if (pc_out !== 16'h2002 || taken !== 1'b1) begin
         failures++;
         $display("FAIL imm_zero pc_out=%h taken=%b want pc_out=2002 taken=1", pc_out, taken);
      end else $display("imm_zero pc_out=%h taken=%b", pc_out, taken);
   endtask

   // Every condition code against every flag combination.
   task automatic test_conditions();
      for (int code = 0; code < 8; code++) begin
         for (int fl = 0; fl < 8; fl++) begin
            int          off;
            int          pc;
            bit          tk;
            logic [15:0] exp_pc;
            off = int'($urandom_range(0, 511)) - 256;
            pc  = int'($urandom_range(0, 65535));
            tk  = model_cond(code, fl[2:0]);
            exp_pc = model_pc(tk, pc, off);
            step(1'b1, code, fl[2:0], off, pc);
            checks++;
            if (pc_out !== exp_pc || taken !== tk) begin
               failures++;
               $display("FAIL cond c=%0d f=%03b pc=%h imm=%0d got pc_out=%h taken=%b want pc_out=%h taken=%b",
                        code, fl[2:0], pc[15:0], off, pc_out, taken, exp_pc, tk);
            end else $display("cond c=%0d f=%03b pc_out=%h taken=%b", code, fl[2:0], pc_out, taken);
         end
      end
   endtask

   // Back-to-back random transactions, including branch=0 with random c/f/imm.
   task automatic test_back_to_back();
      for (int i = 0; i < 150; i++) begin
         bit          br;
         int          code;
         logic [2:0]  fl;
         int          off;
         int          pc;
         bit          tk;
         logic [15:0] exp_pc;
         br   = 1'($urandom);
         code = int'($urandom_range(0, 7));
         fl   = 3'($urandom);
         off  = int'($urandom_range(0, 511)) - 256;
         pc   = int'($urandom_range(0, 65535));
         if (i % 10 == 0) pc = 16'hFFFE;
         tk   = br && model_cond(code, fl);
         exp_pc = model_pc(tk, pc, off);
         step(br, code, fl, off, pc);
         checks++;
         if (pc_out !== exp_pc || taken !== tk) begin
            failures++;
            $display("FAIL rand%0d br=%b c=%0d f=%03b pc=%h imm=%0d got pc_out=%h taken=%b want pc_out=%h taken=%b",
                     i, br, code, fl, pc[15:0], off, pc_out, taken, exp_pc, tk);
         end else $display("rand%0d pc_out=%h taken=%b", i, pc_out, taken);
      end
   endtask

   // Reset mid-operation overrides the pending load; release resumes normally.
   task automatic test_reset_midop();
      step(1'b1, 7, 3'b000, 16, 16'h4000);
      checks++;
      if (pc_out !== 16'h4022 || taken !== 1'b1) begin
         failures++;
         $display("FAIL midop_pre pc_out=%h taken=%b want pc_out=4022 taken=1", pc_out, taken);
      end else $display("midop_pre pc_out=%h taken=%b", pc_out, taken);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (pc_out !== 16'h0000 || taken !== 1'b0) begin
         failures++;
         $display("FAIL midop_async pc_out=%h taken=%b want pc_out=0000 taken=0", pc_out, taken);
      end else $display("midop_async pc_out=%h taken=%b", pc_out, taken);
      @(posedge clk);
      #1;
      checks++;
      if (pc_out !== 16'h0000 || taken !== 1'b0) begin
         failures++;
         $display("FAIL midop_hold pc_out=%h taken=%b want pc_out=0000 taken=0", pc_out, taken);
      end else $display("midop_hold pc_out=%h taken=%b", pc_out, taken);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1, 3'b001, -1, 16'h0300);
      checks++;
      if (pc_out !== 16'h0300 || taken !== 1'b1) begin
         failures++;
         $display("FAIL midop_release pc_out=%h taken=%b want pc_out=0300 taken=1", pc_out, taken);
      end else $display("midop_release pc_out=%h taken=%b", pc_out, taken);
   endtask

   initial begin
      rst    = 1'b1;
      branch = 1'b0;
      c      = UCD;
      f      = 3'b000;
      imm    = 9'sd0;
      pc_in  = 16'h0000;
      #2;
      test_reset();
      test_directed();
      test_conditions();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pc_control
